// File: rtl/waterfall_scroll_ctrl_if.sv
// Memory-side bus of the waterfall scroll controller: bin BRAM read port and
// single-port frame-buffer write/read address port.
interface waterfall_scroll_ctrl_if #(
  parameter int PIX_W  = 8,
  parameter int BIN_AW = 9,
  parameter int FB_AW  = 17
) ();
  logic              bin_re;
  logic [BIN_AW-1:0] bin_addr;
  logic [PIX_W-1:0]  bin_rdata;
  logic [FB_AW-1:0]  fb_addr;
  logic [PIX_W-1:0]  fb_wdata;
  logic              fb_we;

  modport master (
    output bin_re, bin_addr, fb_addr, fb_wdata, fb_we,
    input  bin_rdata
  );

  modport slave (
    input  bin_re, bin_addr, fb_addr, fb_wdata, fb_we,
    output bin_rdata
  );
endinterface

// File: rtl/waterfall_scroll_ctrl.sv
// Scrolling waterfall frame-buffer controller: clear, scrolled video readout and
// per-frame line copy from the bin BRAM. Optional macro WATERFALL_DIR_EN adds dir.
module waterfall_scroll_ctrl #(
  parameter int H_VISIBLE = 320,
  parameter int V_VISIBLE = 240,
  parameter int BINS      = 320,
  parameter int PIX_W     = 8,
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int BIN_AW    = 9,
  parameter int FB_AW     = 17,
  parameter int DIV_W     = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  input  logic             lower_blank,
  input  logic [DIV_W-1:0] scroll_div,
  input  logic             freeze,
  input  logic             clear_req,
`ifdef WATERFALL_DIR_EN
  input  logic             dir,
`endif
  output logic             clearing,
  output logic             line_done,
  waterfall_scroll_ctrl_if.master mem
);

  localparam int K_W = $clog2(H_VISIBLE + 1);

  localparam logic [FB_AW-1:0] CLR_LAST = FB_AW'(H_VISIBLE * V_VISIBLE - 1);
  localparam logic [FB_AW-1:0] H_FB     = FB_AW'(H_VISIBLE);
  localparam logic [Y_W:0]     V_EXT    = (Y_W + 1)'(V_VISIBLE);
  localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_VISIBLE - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(H_VISIBLE);
  localparam logic [K_W-1:0]   K_BINS   = K_W'(BINS);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_VIDEO = 2'd1;
  localparam logic [1:0] ST_LINE  = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic [1:0]        r_state;
  logic [Y_W-1:0]    r_offset;
  logic [DIV_W-1:0]  r_cnt;
  logic [FB_AW-1:0]  r_clr_addr;
  logic              r_clr_pend;
  logic              r_lb_d;
  logic [K_W-1:0]    r_k;
  logic [Y_W-1:0]    r_line;
  logic              r_dir;
  logic [FB_AW-1:0]  r_line_base;
  logic [Y_W-1:0]    r_row;
  logic [X_W-1:0]    r_x_d1;
  logic [FB_AW-1:0]  r_fb_addr;
  logic              r_fb_we;
  logic              r_wr_bin;
  logic              r_bin_re;
  logic [BIN_AW-1:0] r_bin_addr;
  logic              r_line_done;

  logic [Y_W:0]      w_sum;
  logic [Y_W-1:0]    w_row;
  logic              w_lb_rise;
  logic              w_dir;
  logic [Y_W-1:0]    w_line_sel;
  logic [Y_W-1:0]    w_off_nxt;
  logic [K_W-1:0]    w_k_nxt;

`ifdef WATERFALL_DIR_EN
  assign w_dir = dir;
`else
  assign w_dir = 1'b0;
`endif

  // Scrolled row: offset is always < V_VISIBLE, so a single subtract wraps it.
  assign w_sum     = {1'b0, y} + {1'b0, r_offset};
  assign w_row     = (w_sum >= V_EXT) ? Y_W'(w_sum - V_EXT) : w_sum[Y_W-1:0];
  assign w_lb_rise = lower_blank & ~r_lb_d;

  // dir=1 writes the line above the current offset and moves the offset onto it.
  assign w_line_sel = w_dir ? ((r_offset == '0) ? V_LAST : r_offset - 1'b1) : r_offset;
  assign w_off_nxt  = r_dir ? r_line : ((r_line == V_LAST) ? '0 : r_line + 1'b1);
  assign w_k_nxt    = r_k + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_CLEAR;
      r_offset    <= '0;
      r_cnt       <= '0;
      r_clr_addr  <= '0;
      r_clr_pend  <= 1'b0;
      r_lb_d      <= 1'b0;
      r_k         <= '0;
      r_line      <= '0;
      r_dir       <= 1'b0;
      r_line_base <= '0;
      r_row       <= '0;
      r_x_d1      <= '0;
      r_fb_addr   <= '0;
      r_fb_we     <= 1'b0;
      r_wr_bin    <= 1'b0;
      r_bin_re    <= 1'b0;
      r_bin_addr  <= '0;
      r_line_done <= 1'b0;
    end else begin
      r_lb_d      <= lower_blank;
      r_line_done <= 1'b0;
      r_row       <= w_row;
      r_x_d1      <= x;
      if (clear_req) r_clr_pend <= 1'b1;

      case (r_state)
        ST_CLEAR: begin
          r_fb_we    <= 1'b1;
          r_wr_bin   <= 1'b0;
          r_bin_re   <= 1'b0;
          r_bin_addr <= '0;
          r_fb_addr  <= r_clr_addr;
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == CLR_LAST) r_state <= ST_VIDEO;
        end

        ST_LINE: begin
          if (r_k == K_LAST) begin
            r_fb_we     <= 1'b0;
            r_wr_bin    <= 1'b0;
            r_bin_re    <= 1'b0;
            r_bin_addr  <= '0;
            r_offset    <= w_off_nxt;
            r_line_done <= 1'b1;
            r_state     <= ST_WAIT;
          end else begin
            // Bin read for pixel k+1 overlaps the write of pixel k.
            r_bin_re   <= (w_k_nxt < K_BINS);
            r_bin_addr <= (w_k_nxt < K_BINS) ? BIN_AW'(w_k_nxt) : '0;
            r_fb_we    <= 1'b1;
            r_fb_addr  <= r_line_base + FB_AW'(r_k);
            r_wr_bin   <= (r_k < K_BINS);
            r_k        <= w_k_nxt;
          end
        end

        default: begin
          r_fb_we    <= 1'b0;
          r_wr_bin   <= 1'b0;
          r_bin_re   <= 1'b0;
          r_bin_addr <= '0;
          r_fb_addr  <= FB_AW'(r_x_d1) + FB_AW'(r_row) * H_FB;
          if (r_state == ST_WAIT) begin
            if (!lower_blank) r_state <= ST_VIDEO;
          end else if (w_lb_rise) begin
            if (r_clr_pend) begin
              r_clr_pend <= clear_req;
              r_clr_addr <= '0;
              r_state    <= ST_CLEAR;
            end else if (!freeze && (r_cnt == scroll_div)) begin
              r_cnt       <= '0;
              r_k         <= '0;
              r_line      <= w_line_sel;
              r_dir       <= w_dir;
              r_line_base <= FB_AW'(w_line_sel) * H_FB;
              r_bin_re    <= (K_BINS != '0);
              r_bin_addr  <= '0;
              r_state     <= ST_LINE;
            end else begin
              if (!freeze) r_cnt <= r_cnt + 1'b1;
              r_state <= ST_WAIT;
            end
          end
        end
      endcase
    end
  end

  // Bin data arrives combinationally in the write cycle; everything else writes 0.
  assign mem.fb_wdata = r_wr_bin ? mem.bin_rdata : {PIX_W{1'b0}};
  assign mem.fb_we    = r_fb_we;
  assign mem.fb_addr  = r_fb_addr;
  assign mem.bin_re   = r_bin_re;
  assign mem.bin_addr = r_bin_addr;
  assign clearing     = (r_state == ST_CLEAR);
  assign line_done    = r_line_done;

endmodule
